melody_scheduler: RTL and testbench



---
 rtl/melody_scheduler.sv | 166 ++++++++++++++++
 tb/tb_melody_scheduler.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/melody_scheduler.sv
// melody_scheduler: fixed-priority arbiter and note sequencer for the shared
// melody ROM (JukeBox1).
//
// Requesters 0..3 post play requests (pulse or level). Bit 0 has the highest
// priority. The granted requester's melody code is driven to the JukeBox.
// noteIndex then steps through the melody, and each note is held for
// note_length beats of BEAT_CYCLES clocks. A note_length of 0 ends the melody.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   req[3:0]      play requests (bit 0 = highest priority)
//   note_length   beats of current note from the JukeBox (0 = end of melody)
//   melodySelect  melody code to the JukeBox
//   noteIndex     current note index to the JukeBox
//   playing       melody active
//   grant[3:0]    one-hot, the requester being served
//   done          one-cycle pulse on normal completion
//
// Optional feature macro: MELODY_PREEMPT_EN. When it is defined, a pending
// higher-priority request aborts the melody that is playing.
module melody_scheduler #(
  parameter int unsigned BEAT_CYCLES = 12_500_000,
  parameter logic [3:0]  MEL0        = 4'd0,
  parameter logic [3:0]  MEL1        = 4'd1,
  parameter logic [3:0]  MEL2        = 4'd2,
  parameter logic [3:0]  MEL3        = 4'd13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] note_length,
  output logic [3:0] melodySelect,
  output logic [4:0] noteIndex,
  output logic       playing,
  output logic [3:0] grant,
  output logic       done
);

  // Keep the counter at least 1 bit wide so that BEAT_CYCLES=1 still elaborates.
  localparam int unsigned   CW         = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_RELOAD = CW'(BEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_e;

  state_e        state_q;
  logic [3:0]    pend_q, pend_d;
  logic [CW-1:0] cyc_q;
  logic [3:0]    beats_q;
  logic [3:0]    mel_q;
  logic [4:0]    idx_q;
  logic          play_q;
  logic [3:0]    grant_q;
  logic          done_q;

  logic          pick_vld;
  logic [1:0]    pick_idx;
  logic          preempt;
  logic          launch;
  logic [3:0]    pick_mel;

  // Lowest set bit of pend wins. The loop runs downward so that the last hit is the lowest bit.
  always_comb begin
    pick_vld = |pend_q;
    pick_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pend_q[i]) pick_idx = 2'(i);
    end
  end

  always_comb begin
    case (pick_idx)
      2'd0:    pick_mel = MEL0;
      2'd1:    pick_mel = MEL1;
      2'd2:    pick_mel = MEL2;
      default: pick_mel = MEL3;
    endcase
  end

`ifdef MELODY_PREEMPT_EN
  logic [1:0] cur_idx;

  // grant_q is one-hot whenever state is LOAD or PLAY.
  always_comb begin
    cur_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (grant_q[i]) cur_idx = 2'(i);
    end
  end

  assign preempt = (state_q != IDLE) && pick_vld && (pick_idx < cur_idx);
`else
  assign preempt = 1'b0;
`endif

  // A new melody starts from IDLE, or by preemption from LOAD/PLAY.
  assign launch = pick_vld && ((state_q == IDLE) || preempt);

  // Set wins over clear, so a held request re-latches in the same cycle it is granted.
  assign pend_d = (pend_q & ~(launch ? (4'b0001 << pick_idx) : 4'b0000)) | req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= 4'd0;
      cyc_q   <= '0;
      beats_q <= 4'd0;
      mel_q   <= 4'd0;
      idx_q   <= 5'd0;
      play_q  <= 1'b0;
      grant_q <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      done_q <= 1'b0;
      if (launch) begin
        state_q <= LOAD;
        grant_q <= 4'b0001 << pick_idx;
        mel_q   <= pick_mel;
        idx_q   <= 5'd0;
        play_q  <= 1'b1;
      end else begin
        case (state_q)
          IDLE: ;
          LOAD: begin
            if (note_length == 4'd0) begin
              state_q <= IDLE;
              play_q  <= 1'b0;
              grant_q <= 4'd0;
              done_q  <= 1'b1;
            end else begin
              beats_q <= note_length - 4'd1;
              cyc_q   <= CYC_RELOAD;
              state_q <= PLAY;
            end
          end
          PLAY: begin
            if (cyc_q != '0) begin
              cyc_q <= cyc_q - CW'(1);
            end else if (beats_q != 4'd0) begin
              beats_q <= beats_q - 4'd1;
              cyc_q   <= CYC_RELOAD;
            end else if (idx_q == 5'd31) begin
              // Index 31 is the last slot. End the melody here instead of wrapping to 0.
              state_q <= IDLE;
              play_q  <= 1'b0;
              grant_q <= 4'd0;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= idx_q + 5'd1;
              state_q <= LOAD;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign melodySelect = mel_q;
  assign noteIndex    = idx_q;
  assign playing      = play_q;
  assign grant        = grant_q;
  assign done         = done_q;

endmodule

// File: tb/tb_melody_scheduler.sv
// Testbench for melody_scheduler. A table-driven note_length ROM stands in
// for the JukeBox. A reference model tracks the melody as "remaining cycles
// of the current note" and runs beside the DUT.
module tb_melody_scheduler;
  localparam int BC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'd0;
  logic [3:0] note_length;
  logic [3:0] melodySelect;
  logic [4:0] noteIndex;
  logic       playing;
  logic [3:0] grant;
  logic       done;

  int   nvec = 0;
  int   nerr = 0;
  int   rl [16][32];
  logic wrap_mode = 1'b0;

  melody_scheduler #(.BEAT_CYCLES(BC)) dut (
    .clk(clk), .reset(reset), .req(req), .note_length(note_length),
    .melodySelect(melodySelect), .noteIndex(noteIndex), .playing(playing),
    .grant(grant), .done(done)
  );

  always #5 clk = ~clk;

  always_comb note_length = wrap_mode ? 4'd1 : 4'(rl[melodySelect][noteIndex]);

  function automatic logic [3:0] mel_of(input int k);
    case (k)
      0: return 4'd0;
      1: return 4'd1;
      2: return 4'd2;
      default: return 4'd13;
    endcase
  endfunction

  function automatic int lowest(input logic [3:0] p);
    for (int i = 0; i < 4; i++) if (p[i]) return i;
    return 4;
  endfunction

  // Reference model. It tracks busy/requester/index, a "this cycle is the note's
  // load" flag, and the cycles left in the note's hold time (len*BC).
  logic       m_busy = 1'b0, m_load = 1'b0, m_done = 1'b0;
  int         m_k = 0, m_idx = 0, m_rem = 0;
  logic [3:0] m_pend = 4'd0;

  always @(posedge clk) begin : model
    int   j;
    int   ln;
    logic go;
    j  = lowest(m_pend);
    go = !m_busy && (j < 4);
`ifdef MELODY_PREEMPT_EN
    if (m_busy && j < m_k) go = 1'b1;
`endif
    if (reset) begin
      m_busy <= 1'b0; m_load <= 1'b0; m_done <= 1'b0;
      m_k <= 0; m_idx <= 0; m_rem <= 0; m_pend <= 4'd0;
    end else begin
      m_pend <= (go ? (m_pend & ~(4'b0001 << j)) : m_pend) | req;
      m_done <= 1'b0;
      if (go) begin
        m_busy <= 1'b1; m_k <= j; m_idx <= 0; m_load <= 1'b1;
      end else if (m_busy && m_load) begin
        ln = wrap_mode ? 1 : rl[mel_of(m_k)][m_idx];
        if (ln == 0) begin
          m_busy <= 1'b0; m_done <= 1'b1;
        end else begin
          m_rem <= ln * BC; m_load <= 1'b0;
        end
      end else if (m_busy) begin
        if (m_rem > 1) m_rem <= m_rem - 1;
        else if (m_idx == 31) begin
          m_busy <= 1'b0; m_done <= 1'b1;
        end else begin
          m_idx <= m_idx + 1; m_load <= 1'b1;
        end
      end
    end
  end

  logic [3:0] e_grant, e_mel;
  logic [4:0] e_idx;
  logic       mdl_ok;
  assign e_grant = m_busy ? 4'(1 << m_k) : 4'd0;
  assign e_mel   = mel_of(m_k);
  assign e_idx   = 5'(m_idx);
  assign mdl_ok  = (playing === m_busy) && (grant === e_grant) && (done === m_done) &&
                   (!m_busy || (melodySelect === e_mel && noteIndex === e_idx));

  task automatic do_reset();
    reset = 1'b1; req = 4'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int c;
    reset = 1'b1; req = 4'd0;
    repeat (2) @(negedge clk);
    nvec++;
    if ({playing, grant, done, melodySelect, noteIndex} !== 15'd0) begin
      nerr++; $display("FAIL reset_init: got play=%b grant=%b done=%b mel=%0d idx=%0d, want all 0",
                       playing, grant, done, melodySelect, noteIndex);
    end
    reset = 1'b0; req = 4'b0100;
    @(negedge clk); req = 4'd0;
    for (c = 0; c < 10 && !playing; c++) @(negedge clk);
    repeat (12) begin
      @(negedge clk);
      nvec++;
      if (!mdl_ok) begin
        nerr++; $display("FAIL model(reset) @%0t: play=%b grant=%b done=%b idx=%0d, want play=%b grant=%b done=%b idx=%0d",
                         $time, playing, grant, done, noteIndex, m_busy, e_grant, m_done, e_idx);
      end
    end
    // Latch a pending request, then reset mid-note. The pending request must be dropped.
    req = 4'b0010;
    @(negedge clk); req = 4'd0; reset = 1'b1;
    @(negedge clk);
    nvec++;
    if ({playing, grant, done, noteIndex} !== 10'd0) begin
      nerr++; $display("FAIL reset_midplay: got play=%b grant=%b done=%b idx=%0d, want 0 0 0 0",
                       playing, grant, done, noteIndex);
    end
    @(negedge clk); reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      nvec++;
      if (grant !== 4'd0 || playing !== 1'b0) begin
        nerr++; $display("FAIL reset_pend_drop: got grant=%b play=%b, want 0000 0", grant, playing);
      end
    end
  endtask

  task automatic test_single();
    int t [10];
    int prev, t_done, c;
    for (int i = 0; i < 10; i++) t[i] = -1;
    do_reset();
    req = 4'b0100;
    @(negedge clk); req = 4'd0;
    nvec++;
    if (grant !== 4'd0) begin
      nerr++; $display("FAIL single_early_grant: got %b want 0000", grant);
    end
    @(negedge clk);
    nvec++;
    if (grant !== 4'b0100 || playing !== 1'b1 || noteIndex !== 5'd0 || melodySelect !== 4'd2) begin
      nerr++; $display("FAIL single_grant: got grant=%b play=%b idx=%0d mel=%0d, want 0100 1 0 2",
                       grant, playing, noteIndex, melodySelect);
    end
    t[0] = 0; prev = 0; t_done = -1;
    for (c = 1; c < 200; c++) begin
      @(negedge clk);
      nvec++;
      if (!mdl_ok) begin
        nerr++; $display("FAIL model(single) @%0t: play=%b grant=%b done=%b idx=%0d, want play=%b grant=%b done=%b idx=%0d",
                         $time, playing, grant, done, noteIndex, m_busy, e_grant, m_done, e_idx);
      end
      if (done) begin t_done = c; break; end
      if (playing && int'(noteIndex) != prev) begin
        nvec++;
        if (int'(noteIndex) != prev + 1 || noteIndex > 5'd9) begin
          nerr++; $display("FAIL single_step: got idx=%0d want %0d", noteIndex, prev + 1);
        end
        prev = int'(noteIndex);
        if (prev < 10) t[prev] = c;
      end
    end
    nvec++;
    if (t[1] !== 9) begin nerr++; $display("FAIL single_note0_len: got %0d want 9", t[1]); end
    nvec++;
    if (t[9] - t[8] !== 25) begin nerr++; $display("FAIL single_note8_len: got %0d want 25", t[9] - t[8]); end
    nvec++;
    if (t_done !== 98) begin nerr++; $display("FAIL single_done_time: got %0d want 98", t_done); end
    nvec++;
    if (prev !== 9) begin nerr++; $display("FAIL single_last_idx: got %0d want 9", prev); end
  endtask

  task automatic test_simult();
    logic seen;
    do_reset();
    req = 4'b1010;
    @(negedge clk); req = 4'd0;
    @(negedge clk);
    nvec++;
    if (grant !== 4'b0010) begin nerr++; $display("FAIL simult_first: got %b want 0010", grant); end
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      nvec++;
      if (!mdl_ok) begin
        nerr++; $display("FAIL model(simult) @%0t: play=%b grant=%b done=%b idx=%0d, want play=%b grant=%b done=%b idx=%0d",
                         $time, playing, grant, done, noteIndex, m_busy, e_grant, m_done, e_idx);
      end
      if (done) begin
        seen = 1'b1;
        nvec++;
        if (grant !== 4'd0 || playing !== 1'b0) begin
          nerr++; $display("FAIL simult_done_idle: got grant=%b play=%b want 0000 0", grant, playing);
        end
        @(negedge clk);
        nvec++;
        if (grant !== 4'b1000) begin nerr++; $display("FAIL simult_second: got %b want 1000", grant); end
      end
    end
    nvec++;
    if (!seen) begin nerr++; $display("FAIL simult_timeout: got no done, want done within 200 cycles"); end
  endtask

  task automatic test_held();
    int   runs;
    logic chk_next;
    do_reset();
    req = 4'b0001;
    runs = 0; chk_next = 1'b0;
    for (int c = 0; c < 400 && (runs < 2 || chk_next); c++) begin
      @(negedge clk);
      nvec++;
      if (!mdl_ok) begin
        nerr++; $display("FAIL model(held) @%0t: play=%b grant=%b done=%b idx=%0d, want play=%b grant=%b done=%b idx=%0d",
                         $time, playing, grant, done, noteIndex, m_busy, e_grant, m_done, e_idx);
      end
      if (chk_next) begin
        chk_next = 1'b0;
        nvec++;
        if (grant !== 4'b0001 || playing !== 1'b1 || noteIndex !== 5'd0) begin
          nerr++; $display("FAIL held_replay: got grant=%b play=%b idx=%0d want 0001 1 0", grant, playing, noteIndex);
        end
      end
      if (done) begin
        runs++;
        chk_next = 1'b1;
        nvec++;
        if (playing !== 1'b0 || grant !== 4'd0) begin
          nerr++; $display("FAIL held_gap: got play=%b grant=%b want 0 0000", playing, grant);
        end
      end
    end
    req = 4'd0;
    nvec++;
    if (runs < 2) begin nerr++; $display("FAIL held_timeout: got %0d completions want 2", runs); end
  endtask

  task automatic test_preempt();
    int   c;
    logic seen;
    do_reset();
    req = 4'b1000;
    @(negedge clk); req = 4'd0;
    for (c = 0; c < 100 && !(playing && noteIndex == 5'd3); c++) begin
      @(negedge clk);
      nvec++;
      if (!mdl_ok) begin
        nerr++; $display("FAIL model(preempt) @%0t: play=%b grant=%b done=%b idx=%0d, want play=%b grant=%b done=%b idx=%0d",
                         $time, playing, grant, done, noteIndex, m_busy, e_grant, m_done, e_idx);
      end
    end
    repeat (2) @(negedge clk);
    req = 4'b0001;
    @(negedge clk); req = 4'd0;
    seen = done;
    @(negedge clk);
    seen = seen | done;
`ifdef MELODY_PREEMPT_EN
    nvec++;
    if (grant !== 4'b0001 || noteIndex !== 5'd0 || playing !== 1'b1 || seen !== 1'b0) begin
      nerr++; $display("FAIL preempt_switch: got grant=%b idx=%0d play=%b done_seen=%b want 0001 0 1 0",
                       grant, noteIndex, playing, seen);
    end
`else
    nvec++;
    if (grant !== 4'b1000 || seen !== 1'b0) begin
      nerr++; $display("FAIL nopreempt_hold: got grant=%b done_seen=%b want 1000 0", grant, seen);
    end
    seen = 1'b0;
    for (c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        @(negedge clk);
        nvec++;
        if (grant !== 4'b0001) begin nerr++; $display("FAIL nopreempt_next: got %b want 0001", grant); end
      end
    end
    nvec++;
    if (!seen) begin nerr++; $display("FAIL nopreempt_timeout: got no done, want done within 100 cycles"); end
`endif
    repeat (80) begin
      @(negedge clk);
      nvec++;
      if (!mdl_ok) begin
        nerr++; $display("FAIL model(preempt_tail) @%0t: play=%b grant=%b done=%b idx=%0d, want play=%b grant=%b done=%b idx=%0d",
                         $time, playing, grant, done, noteIndex, m_busy, e_grant, m_done, e_idx);
      end
    end
  endtask

  task automatic test_wrap();
    int   t_done, last;
    logic seen_nz, bad;
    do_reset();
    wrap_mode = 1'b1;
    req = 4'b0001;
    @(negedge clk); req = 4'd0;
    @(negedge clk);
    t_done = -1; last = 0; seen_nz = 1'b0; bad = 1'b0;
    for (int c = 1; c < 300; c++) begin
      @(negedge clk);
      nvec++;
      if (!mdl_ok) begin
        nerr++; $display("FAIL model(wrap) @%0t: play=%b grant=%b done=%b idx=%0d, want play=%b grant=%b done=%b idx=%0d",
                         $time, playing, grant, done, noteIndex, m_busy, e_grant, m_done, e_idx);
      end
      if (done) begin t_done = c; break; end
      if (playing) begin
        if (noteIndex != 5'd0) seen_nz = 1'b1;
        else if (seen_nz) bad = 1'b1;
        last = int'(noteIndex);
      end
    end
    wrap_mode = 1'b0;
    nvec++;
    if (t_done !== 160) begin nerr++; $display("FAIL wrap_done_time: got %0d want 160", t_done); end
    nvec++;
    if (bad !== 1'b0 || last !== 31) begin
      nerr++; $display("FAIL wrap_index: got wrapped=%b last=%0d want 0 31", bad, last);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk);
      nvec++;
      if (!mdl_ok) begin
        nerr++; $display("FAIL model(random) @%0t: play=%b grant=%b done=%b mel=%0d idx=%0d, want play=%b grant=%b done=%b mel=%0d idx=%0d",
                         $time, playing, grant, done, melodySelect, noteIndex, m_busy, e_grant, m_done, e_mel, e_idx);
      end
      if (c < 900) begin
        req   = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        reset = ($urandom_range(0, 149) == 0);
      end else begin
        req = 4'd0; reset = 1'b0;
      end
    end
  endtask

  initial begin
    for (int m = 0; m < 16; m++)
      for (int i = 0; i < 32; i++) rl[m][i] = 0;
    for (int i = 0; i < 8; i++) rl[2][i] = 2;
    rl[2][8] = 6;
    for (int i = 0; i < 4; i++) rl[13][i] = 2;
    for (int m = 0; m < 2; m++) begin
      int n;
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < n; i++) rl[m][i] = int'($urandom_range(1, 3));
    end

    test_reset();
    test_single();
    test_simult();
    test_held();
    test_preempt();
    test_wrap();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
